reg16x8_loader: RTL and testbench
=================================

Name: reg16x8_loader

Overview:
- Writer/feeder side of the 16x8 register-file scan flow.
- Accepts bytes over a valid/ready stream and writes them sequentially into the 16-entry, 8-bit register file through its write port.
- After the last write, pulses `go` to the scan controller and waits for its `done`.
- Sits between the input stream and the register file / scan controller pair, so a full array is loaded before every scan.

Parameters:
- DEPTH, 16, number of register-file entries to fill per frame (power of 2, ≥2).
- WIDTH, 8, data width of each entry.
- ADDR_W, 4, write-address width; equals log2(DEPTH).

Ports:
- Clk  in  1  clock; all state changes on rising edge.
- Rst  in  1  asynchronous, active-high reset.
- start  in  1  begin a new frame load; sampled only in IDLE.
- in_valid  in  1  input byte valid.
- in_data  in  WIDTH  input byte.
- in_ready  out  1  loader can accept a byte this cycle.
- W_en  out  1  register-file write strobe, one cycle per accepted byte.
- W_Addr  out  ADDR_W  register-file write address.
- W_Data  out  WIDTH  register-file write data.
- go  out  1  one-cycle start pulse to the scan controller.
- scan_done  in  1  done from the scan controller.
- busy  out  1  high in every state except IDLE.
- loaded  out  1  sticky: frame loaded and scanned; cleared on next accepted start.
- count  out  ADDR_W+1  bytes accepted in the current frame, 0..DEPTH.

Behaviour:
- Reset values:
  - state=IDLE.
  - in_ready, W_en, go, busy, loaded = 0.
  - W_Addr, W_Data, count = 0.
- Reset mid-operation aborts immediately; the partial frame is discarded and no `go` is issued.
- States: IDLE, FILL, FLUSH, KICK, WAIT.
- IDLE:
  - in_ready=0.
  - start=1 → FILL next cycle; count←0, loaded←0.
- FILL:
  - in_ready=1 (combinational from state).
  - Handshake: a byte is accepted on a rising edge where in_valid && in_ready.
  - At the accepting edge: W_en←1, W_Addr←count[ADDR_W-1:0], W_Data←in_data, count←count+1.
  - W_en is therefore registered: it is high for exactly the one cycle following acceptance.
  - Addresses are written in order 0..DEPTH-1, with no wrap within a frame.
  - Accepting the DEPTH-th byte (count goes DEPTH-1→DEPTH) → FLUSH; in_ready drops in the next cycle.
  - in_valid low: hold state, W_en←0.
- FLUSH: one cycle. The last W_en is high here and the write lands at the end of this cycle → KICK.
- KICK:
  - go=1 for exactly one cycle; W_en=0 → WAIT.
  - `go` is never asserted before entry DEPTH-1 has been written.
- WAIT:
  - Hold all outputs; in_ready=0.
  - On scan_done=1 → loaded←1, IDLE.
  - No timeout unless the optional feature is enabled.
- Boundary conditions:
  - start outside IDLE is ignored.
  - scan_done outside WAIT is ignored.
  - scan_done already high on entry to WAIT completes on the first WAIT cycle.
  - start held high continuously in IDLE immediately begins the next frame; back-to-back frames are allowed.
  - in_data is ignored whenever in_ready=0.
- Latency: minimum DEPTH+3 cycles from start to go with in_valid held high (1 IDLE→FILL, DEPTH accepts, FLUSH, KICK).
- count saturates at DEPTH; no arithmetic overflow is possible.

Optional Feature:
- Macro: LOADER_TIMEOUT_EN.
- When defined:
  - Parameter TIMEOUT, default 255, and output `timeout` (1 bit) are added.
  - A counter runs in WAIT; if scan_done has not arrived after TIMEOUT cycles → IDLE with timeout←1 (sticky until the next accepted start) and loaded stays 0.
- When undefined: WAIT waits indefinitely; no timeout port or counter exists.

Decomposition:
- Package loader_pkg:
  - state enum (IDLE, FILL, FLUSH, KICK, WAIT).
  - DEPTH/WIDTH/ADDR_W default constants.
  - TIMEOUT default.
- One natural sub-module, fill_counter:
  - Saturating ADDR_W+1-bit counter with clear and increment.
  - Reused for the timeout counter.

Test Plan:
- Rst mid-FILL after 5 accepts → all outputs 0, state IDLE, no go; a following start reloads from address 0.
- start=1, in_valid held 1, data 0x00..0x0F → W_en on 16 consecutive cycles, W_Addr 0..15 matching data; go pulses exactly 19 cycles after start sampled; scan_done → loaded=1.
- in_valid toggling 1,0,1,0 → W_en only after valid-high cycles; count increments only on accepts; in_ready stays 1 throughout FILL.
- start pulses during FILL and WAIT, and scan_done pulses during FILL → no effect; frame still completes with a single go.
- Back-to-back: start held high through completion → second frame begins the cycle after return to IDLE; loaded clears on that start.
- With LOADER_TIMEOUT_EN and TIMEOUT=10, scan_done never asserted → IDLE after 10 WAIT cycles, timeout=1, loaded=0.

Source files
------------

// File: rtl/loader_pkg.sv
// Shared types and default constants for the reg16x8 loader.
// Optional feature macro: LOADER_TIMEOUT_EN (scan-done timeout, uses TIMEOUT_DEF).
package loader_pkg;

    localparam int unsigned DEPTH_DEF   = 16;
    localparam int unsigned WIDTH_DEF   = 8;
    localparam int unsigned ADDR_W_DEF  = 4;
    localparam int unsigned TIMEOUT_DEF = 255;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FILL  = 3'd1,
        FLUSH = 3'd2,
        KICK  = 3'd3,
        WAIT  = 3'd4
    } state_e;

endpackage

// File: rtl/reg16x8_loader_if.sv
// Stream / register-file / scan-controller bundle for the reg16x8 loader.
// Signals:
//   start, in_valid, in_data, scan_done : driven by the master (stream source side)
//   in_ready, w_en, w_addr, w_data, go  : driven by the slave (loader)
interface reg16x8_loader_if #(
    parameter int unsigned WIDTH  = loader_pkg::WIDTH_DEF,
    parameter int unsigned ADDR_W = loader_pkg::ADDR_W_DEF
);
    logic              start;
    logic              in_valid;
    logic [WIDTH-1:0]  in_data;
    logic              in_ready;
    logic              w_en;
    logic [ADDR_W-1:0] w_addr;
    logic [WIDTH-1:0]  w_data;
    logic              go;
    logic              scan_done;

    modport master (
        output start, in_valid, in_data, scan_done,
        input  in_ready, w_en, w_addr, w_data, go
    );

    modport slave (
        input  start, in_valid, in_data, scan_done,
        output in_ready, w_en, w_addr, w_data, go
    );
endinterface

// File: rtl/fill_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
// Ports: clk_i, rst_i (async, active-high), clr_i, inc_i, count_o[W-1:0].
module fill_counter #(
    parameter int unsigned W   = 5,
    parameter int unsigned MAX = 16
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] count_o
);
    logic [W-1:0] count_q, count_d;

    // Next count: clear, else increment until MAX
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i && (count_q != W'(MAX))) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
endmodule

// File: rtl/reg16x8_loader.sv
// Loads DEPTH stream bytes into the register file in address order, then kicks
// the scan controller with a one-cycle go and waits for its done.
// Ports:
//   clk_i, rst_i          clock, asynchronous active-high reset
//   bus (slave)           stream in (start/in_valid/in_data/in_ready),
//                         register-file write port (w_en/w_addr/w_data),
//                         scan controller handshake (go/scan_done)
//   busy_o                high outside IDLE
//   loaded_o              sticky frame-loaded-and-scanned flag
//   count_o               bytes accepted in the current frame (0..DEPTH)
//   timeout_o             (LOADER_TIMEOUT_EN only) sticky scan-done timeout flag
// Optional feature macro: LOADER_TIMEOUT_EN adds parameter TIMEOUT and timeout_o.
module reg16x8_loader
    import loader_pkg::*;
#(
    parameter int unsigned DEPTH   = DEPTH_DEF,
    parameter int unsigned WIDTH   = WIDTH_DEF,
    parameter int unsigned ADDR_W  = ADDR_W_DEF
`ifdef LOADER_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
`endif
) (
    input  logic            clk_i,
    input  logic            rst_i,
    reg16x8_loader_if.slave bus,
    output logic            busy_o,
    output logic            loaded_o,
    output logic [ADDR_W:0] count_o
`ifdef LOADER_TIMEOUT_EN
    ,
    output logic            timeout_o
`endif
);
    localparam int unsigned      CNT_W    = ADDR_W + 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DEPTH - 1);

    state_e            state_q, state_d;
    logic              w_en_q, w_en_d;
    logic [ADDR_W-1:0] w_addr_q, w_addr_d;
    logic [WIDTH-1:0]  w_data_q, w_data_d;
    logic              go_q, go_d;
    logic              busy_q, busy_d;
    logic              loaded_q, loaded_d;
    logic              cnt_clr, cnt_inc;
    logic [CNT_W-1:0]  cnt;
    logic              accept;

    assign accept = (state_q == FILL) && bus.in_valid;

    // Bytes accepted this frame; doubles as the next write address
    fill_counter #(.W(CNT_W), .MAX(DEPTH)) u_fill_cnt (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clr_i   (cnt_clr),
        .inc_i   (cnt_inc),
        .count_o (cnt)
    );

`ifdef LOADER_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);

    logic             tmo_clr, tmo_inc, tmo_hit;
    logic             timeout_q, timeout_d;
    logic [TMO_W-1:0] tmo_cnt;

    // Cycles spent in WAIT; cleared in KICK so it starts at 0 on WAIT entry
    fill_counter #(.W(TMO_W), .MAX(TIMEOUT)) u_tmo_cnt (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clr_i   (tmo_clr),
        .inc_i   (tmo_inc),
        .count_o (tmo_cnt)
    );

    assign tmo_hit = (tmo_cnt == TMO_W'(TIMEOUT - 1));
`endif

    // Next-state and registered-output logic
    always_comb begin
        state_d  = state_q;
        w_en_d   = 1'b0;
        w_addr_d = w_addr_q;
        w_data_d = w_data_q;
        go_d     = 1'b0;
        loaded_d = loaded_q;
        cnt_clr  = 1'b0;
        cnt_inc  = 1'b0;
`ifdef LOADER_TIMEOUT_EN
        tmo_clr   = 1'b0;
        tmo_inc   = 1'b0;
        timeout_d = timeout_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d  = FILL;
                    cnt_clr  = 1'b1;
                    loaded_d = 1'b0;
`ifdef LOADER_TIMEOUT_EN
                    timeout_d = 1'b0;
`endif
                end
            end
            FILL: begin
                if (accept) begin
                    w_en_d   = 1'b1;
                    w_addr_d = cnt[ADDR_W-1:0];
                    w_data_d = bus.in_data;
                    cnt_inc  = 1'b1;
                    if (cnt == LAST_IDX) begin
                        state_d = FLUSH;
                    end
                end
            end
            FLUSH: begin
                // last write lands at the end of this cycle; go follows it
                state_d = KICK;
                go_d    = 1'b1;
            end
            KICK: begin
                state_d = WAIT;
`ifdef LOADER_TIMEOUT_EN
                tmo_clr = 1'b1;
`endif
            end
            WAIT: begin
                if (bus.scan_done) begin
                    loaded_d = 1'b1;
                    state_d  = IDLE;
                end
`ifdef LOADER_TIMEOUT_EN
                else if (tmo_hit) begin
                    timeout_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    tmo_inc = 1'b1;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            w_en_q   <= 1'b0;
            w_addr_q <= '0;
            w_data_q <= '0;
            go_q     <= 1'b0;
            busy_q   <= 1'b0;
            loaded_q <= 1'b0;
`ifdef LOADER_TIMEOUT_EN
            timeout_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            w_en_q   <= w_en_d;
            w_addr_q <= w_addr_d;
            w_data_q <= w_data_d;
            go_q     <= go_d;
            busy_q   <= busy_d;
            loaded_q <= loaded_d;
`ifdef LOADER_TIMEOUT_EN
            timeout_q <= timeout_d;
`endif
        end
    end

    assign bus.in_ready = (state_q == FILL);
    assign bus.w_en     = w_en_q;
    assign bus.w_addr   = w_addr_q;
    assign bus.w_data   = w_data_q;
    assign bus.go       = go_q;
    assign busy_o       = busy_q;
    assign loaded_o     = loaded_q;
    assign count_o      = cnt;
`ifdef LOADER_TIMEOUT_EN
    assign timeout_o    = timeout_q;
`endif
endmodule

// File: tb/tb_reg16x8_loader.sv
// Directed scoreboard bench for reg16x8_loader (define LOADER_TIMEOUT_EN to
// also exercise the scan-done timeout with TIMEOUT=10).
module tb_reg16x8_loader;
    localparam int unsigned DEPTH  = 16;
    localparam int unsigned WIDTH  = 8;
    localparam int unsigned ADDR_W = 4;
`ifdef LOADER_TIMEOUT_EN
    localparam int unsigned TMO    = 10;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            busy;
    logic            loaded;
    logic [ADDR_W:0] count;
`ifdef LOADER_TIMEOUT_EN
    logic            timeout;
`endif

    int checks   = 0;
    int failures = 0;
    int acc      = 0;
    int wen_cnt  = 0;
    int wen_base = 0;
    int go_cnt   = 0;
    logic [ADDR_W+WIDTH-1:0] sb_q[$];

    reg16x8_loader_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) bus ();

    reg16x8_loader #(
        .DEPTH  (DEPTH),
        .WIDTH  (WIDTH),
        .ADDR_W (ADDR_W)
`ifdef LOADER_TIMEOUT_EN
        ,
        .TIMEOUT(TMO)
`endif
    ) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .bus      (bus),
        .busy_o   (busy),
        .loaded_o (loaded),
        .count_o  (count)
`ifdef LOADER_TIMEOUT_EN
        ,
        .timeout_o(timeout)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock; outputs sampled 1 time unit after the edge, writes scored here
    task automatic tick();
        logic [ADDR_W+WIDTH-1:0] e;
        @(posedge clk);
        #1;
        if (bus.w_en === 1'b1) begin
            wen_cnt++;
            if (sb_q.size() == 0) begin
                chk("wen_unexpected", 32'(bus.w_en), 32'd0);
            end else begin
                e = sb_q.pop_front();
                chk("w_addr", 32'(bus.w_addr), 32'(e[ADDR_W+WIDTH-1:WIDTH]));
                chk("w_data", 32'(bus.w_data), 32'(e[WIDTH-1:0]));
            end
        end
        if (bus.go === 1'b1) begin
            go_cnt++;
            chk("go_after_all_writes", 32'(wen_cnt - wen_base), 32'(DEPTH));
        end
    endtask

    // Drive one cycle of stream input; a byte offered while in_ready is accepted
    task automatic drive(input logic v, input logic [WIDTH-1:0] d);
        bus.in_valid = v;
        bus.in_data  = d;
        if (v && (bus.in_ready === 1'b1)) begin
            sb_q.push_back({ADDR_W'(acc), d});
            acc++;
        end
        tick();
    endtask

    // Start a frame and feed it until go; n counts edges from the start-sampling edge
    task automatic run_fill(input bit toggle, input bit rnd, input bit hold_start,
                            input bit inject, output int go_n, output int last_n);
        logic             v;
        logic [WIDTH-1:0] d;
        acc      = 0;
        wen_base = wen_cnt;
        go_n     = 0;
        last_n   = 0;
        bus.start = 1'b1;
        for (int n = 1; n <= 80 && go_n == 0; n++) begin
            v = toggle ? ((n % 2) == 0) : 1'b1;
            d = rnd ? WIDTH'($urandom) : WIDTH'(acc);
            if (n > 1) bus.start = hold_start || (inject && (n == 4 || n == 5));
            bus.scan_done = inject && (n == 6);
            drive(v, d);
            if (acc == int'(DEPTH) && last_n == 0) last_n = n;
            if (n == 1) chk("loaded_cleared_on_start", 32'(loaded), 32'd0);
            chk("fill_count", 32'(count), 32'(acc));
            chk("fill_in_ready", 32'(bus.in_ready), 32'(acc < int'(DEPTH)));
            chk("fill_busy", 32'(busy), 32'd1);
            if (bus.go === 1'b1) go_n = n;
        end
        if (go_n == 0) chk("go_timeout", 32'd0, 32'd1);
        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        bus.in_valid  = 1'b0;
        bus.scan_done = 1'b0;
    endtask

    // Sit in WAIT (with an ignored start), confirm one go, then complete the scan
    task automatic finish_frame(input int go_base);
        for (int i = 0; i < 3; i++) begin
            bus.start = (i == 1);
            tick();
            chk("wait_busy", 32'(busy), 32'd1);
            chk("wait_in_ready", 32'(bus.in_ready), 32'd0);
            chk("wait_loaded", 32'(loaded), 32'd0);
        end
        bus.start = 1'b0;
        chk("single_go", 32'(go_cnt - go_base), 32'd1);
        bus.scan_done = 1'b1;
        tick();
        bus.scan_done = 1'b0;
        chk("loaded_set", 32'(loaded), 32'd1);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("count_full", 32'(count), 32'(DEPTH));
        tick();
        chk("loaded_sticky", 32'(loaded), 32'd1);
    endtask

    initial begin
        int go_n;
        int last_n;
        int go_base;
        int n;
        bus.start     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.scan_done = 1'b0;

        // Reset values
        #2 rst = 1'b1;
        tick();
        tick();
        chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
        chk("rst_w_en", 32'(bus.w_en), 32'd0);
        chk("rst_go", 32'(bus.go), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_loaded", 32'(loaded), 32'd0);
        chk("rst_w_addr", 32'(bus.w_addr), 32'd0);
        chk("rst_w_data", 32'(bus.w_data), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
`ifdef LOADER_TIMEOUT_EN
        chk("rst_timeout", 32'(timeout), 32'd0);
`endif
        rst = 1'b0;
        tick();
        chk("idle_no_start", 32'(busy), 32'd0);

        // Full frame, valid held, data equals address
        go_base = go_cnt;
        run_fill(1'b0, 1'b0, 1'b0, 1'b0, go_n, last_n);
        // cycles counted with the start-sampling cycle as cycle 1
        chk("start_to_go_cycles", 32'(go_n + 1), 32'(DEPTH + 3));
        chk("go_after_last_accept", 32'(go_n - last_n), 32'd1);
        finish_frame(go_base);
        chk("held_w_addr", 32'(bus.w_addr), 32'(DEPTH - 1));
        chk("held_w_data", 32'(bus.w_data), 32'h0F);

        // Valid toggling, random data, start/scan_done pulses during FILL
        go_base = go_cnt;
        run_fill(1'b1, 1'b1, 1'b0, 1'b1, go_n, last_n);
        chk("toggle_last_accept_cycle", 32'(last_n), 32'(2 * DEPTH));
        chk("toggle_go_after_last_accept", 32'(go_n - last_n), 32'd1);
        finish_frame(go_base);

        // Back-to-back: start held high, scan_done already high on WAIT entry
        go_base = go_cnt;
        run_fill(1'b0, 1'b1, 1'b1, 1'b0, go_n, last_n);
        bus.scan_done = 1'b1;
        tick();
        chk("b2b_wait_busy", 32'(busy), 32'd1);
        chk("b2b_wait_loaded", 32'(loaded), 32'd0);
        tick();
        bus.scan_done = 1'b0;
        chk("b2b_idle_busy", 32'(busy), 32'd0);
        chk("b2b_idle_loaded", 32'(loaded), 32'd1);
        chk("b2b_single_go", 32'(go_cnt - go_base), 32'd1);
        go_base = go_cnt;
        run_fill(1'b0, 1'b1, 1'b0, 1'b0, go_n, last_n);
        chk("b2b_second_latency", 32'(go_n + 1), 32'(DEPTH + 3));
        finish_frame(go_base);

        // Reset after 5 accepts aborts the frame; next frame restarts at address 0
        acc       = 0;
        wen_base  = wen_cnt;
        bus.start = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            drive(1'b1, WIDTH'(8'h50 + k));
            bus.start = 1'b0;
        end
        bus.in_valid = 1'b0;
        chk("pre_reset_count", 32'(count), 32'd5);
        rst = 1'b1;
        #1;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_count", 32'(count), 32'd0);
        chk("mid_rst_in_ready", 32'(bus.in_ready), 32'd0);
        chk("mid_rst_w_en", 32'(bus.w_en), 32'd0);
        chk("mid_rst_w_addr", 32'(bus.w_addr), 32'd0);
        chk("mid_rst_w_data", 32'(bus.w_data), 32'd0);
        chk("mid_rst_loaded", 32'(loaded), 32'd0);
        chk("mid_rst_go", 32'(bus.go), 32'd0);
        sb_q.delete();
        go_base = go_cnt;
        tick();
        tick();
        rst = 1'b0;
        tick();
        tick();
        chk("no_go_after_reset", 32'(go_cnt - go_base), 32'd0);
        chk("post_reset_idle", 32'(busy), 32'd0);
        run_fill(1'b0, 1'b1, 1'b0, 1'b0, go_n, last_n);
        finish_frame(go_base);

`ifdef LOADER_TIMEOUT_EN
        // scan_done never arrives: back to IDLE after TMO WAIT cycles
        go_base = go_cnt;
        run_fill(1'b0, 1'b1, 1'b0, 1'b0, go_n, last_n);
        n = 0;
        while (busy === 1'b1 && n < 60) begin
            tick();
            n++;
        end
        chk("timeout_edges_to_idle", 32'(n), 32'(TMO + 1));
        chk("timeout_flag", 32'(timeout), 32'd1);
        chk("timeout_loaded", 32'(loaded), 32'd0);
        chk("timeout_single_go", 32'(go_cnt - go_base), 32'd1);
`else
        n = 0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
